// File: rtl/axi_lite_interface.sv
// Single-beat AXI slave to simple register port adapter (one transaction in flight).
// Define AXI_LITE_IF_ASSERT_EN to compile in simulation-only protocol checks.

package ariane_axi;
  localparam int unsigned AddrWidth    = 64;
  localparam int unsigned DataWidth    = 64;
  localparam int unsigned StrbWidth    = DataWidth / 8;
  localparam int unsigned IdWidthSlave = 10;

  typedef logic [AddrWidth-1:0]    addr_t;
  typedef logic [DataWidth-1:0]    data_t;
  typedef logic [StrbWidth-1:0]    strb_t;
  typedef logic [IdWidthSlave-1:0] id_slv_t;

  typedef struct packed {
    id_slv_t    id;
    addr_t      addr;
    logic [7:0] len;
    logic [2:0] size;
    logic [1:0] burst;
    logic       lock;
    logic [3:0] cache;
    logic [2:0] prot;
    logic [3:0] qos;
    logic [3:0] region;
    logic [5:0] atop;
  } aw_chan_t;

  typedef struct packed {
    data_t data;
    strb_t strb;
    logic  last;
  } w_chan_t;

  typedef struct packed {
    id_slv_t    id;
    logic [1:0] resp;
  } b_chan_t;

  typedef struct packed {
    id_slv_t    id;
    addr_t      addr;
    logic [7:0] len;
    logic [2:0] size;
    logic [1:0] burst;
    logic       lock;
    logic [3:0] cache;
    logic [2:0] prot;
    logic [3:0] qos;
    logic [3:0] region;
  } ar_chan_t;

  typedef struct packed {
    id_slv_t    id;
    data_t      data;
    logic [1:0] resp;
    logic       last;
  } r_chan_t;

  typedef struct packed {
    aw_chan_t aw;
    logic     aw_valid;
    w_chan_t  w;
    logic     w_valid;
    logic     b_ready;
    ar_chan_t ar;
    logic     ar_valid;
    logic     r_ready;
  } req_slv_t;

  typedef struct packed {
    logic    aw_ready;
    logic    ar_ready;
    logic    w_ready;
    logic    b_valid;
    b_chan_t b;
    logic    r_valid;
    r_chan_t r;
  } resp_slv_t;
endpackage

module axi_lite_interface #(
  parameter int unsigned AXI_ADDR_WIDTH = 64,
  parameter int unsigned AXI_DATA_WIDTH = 64,
  parameter int unsigned AXI_ID_WIDTH   = 10
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  ariane_axi::req_slv_t        axi_req_i,
  output ariane_axi::resp_slv_t       axi_resp_o,
  output logic [AXI_ADDR_WIDTH-1:0]   address_o,
  output logic                        en_o,
  output logic                        we_o,
  input  logic [AXI_DATA_WIDTH-1:0]   data_i,
  output logic [AXI_DATA_WIDTH-1:0]   data_o
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, WRITE_B} state_t;

  state_t                    state_q;
  logic [AXI_ADDR_WIDTH-1:0] address_q;
  logic [AXI_ID_WIDTH-1:0]   id_q;
  logic                      unused_req;

  // Unused request fields (len, size, burst, strb, ...) are intentionally ignored.
  assign unused_req = ^axi_req_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      address_q <= '0;
      id_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          // Read has priority; a concurrent AW waits until the next visit to IDLE.
          if (axi_req_i.ar_valid) begin
            address_q <= axi_req_i.ar.addr;
            id_q      <= axi_req_i.ar.id;
            state_q   <= READ;
          end else if (axi_req_i.aw_valid) begin
            address_q <= axi_req_i.aw.addr;
            id_q      <= axi_req_i.aw.id;
            state_q   <= WRITE;
          end
        end
        READ:    if (axi_req_i.r_ready) state_q <= IDLE;
        WRITE:   if (axi_req_i.w_valid) state_q <= WRITE_B;
        WRITE_B: if (axi_req_i.b_ready) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Gating with rst_ni keeps every ready/valid low while reset is held.
  always_comb begin
    axi_resp_o = '0;
    en_o       = 1'b0;
    we_o       = 1'b0;
    if (rst_ni) begin
      case (state_q)
        IDLE: begin
          axi_resp_o.ar_ready = axi_req_i.ar_valid;
          axi_resp_o.aw_ready = axi_req_i.aw_valid & ~axi_req_i.ar_valid;
        end
        READ: begin
          en_o                = 1'b1;
          axi_resp_o.r_valid  = 1'b1;
          axi_resp_o.r.data   = data_i;
          axi_resp_o.r.id     = id_q;
          axi_resp_o.r.resp   = 2'b00;
          axi_resp_o.r.last   = 1'b1;
        end
        WRITE: begin
          axi_resp_o.w_ready = 1'b1;
          en_o               = axi_req_i.w_valid;
          we_o               = axi_req_i.w_valid;
        end
        WRITE_B: begin
          axi_resp_o.b_valid = 1'b1;
          axi_resp_o.b.id    = id_q;
          axi_resp_o.b.resp  = 2'b00;
        end
        default: ;
      endcase
    end
  end

  assign address_o = address_q;
  assign data_o    = axi_req_i.w.data;

`ifdef AXI_LITE_IF_ASSERT_EN
  initial begin
    if (AXI_DATA_WIDTH != 64) $fatal(1, "axi_lite_interface: AXI_DATA_WIDTH must be 64");
  end

  always @(posedge clk_i) begin
    if (rst_ni) begin
      if (axi_resp_o.ar_ready && axi_req_i.ar_valid && axi_req_i.ar.len != 8'd0)
        $error("axi_lite_interface: burst AR accepted (len=%0d)", axi_req_i.ar.len);
      if (axi_resp_o.aw_ready && axi_req_i.aw_valid && axi_req_i.aw.len != 8'd0)
        $error("axi_lite_interface: burst AW accepted (len=%0d)", axi_req_i.aw.len);
      if (axi_req_i.w_valid && !axi_req_i.w.last)
        $error("axi_lite_interface: W beat without last");
    end
  end
`endif

endmodule

// File: tb/tb_axi_lite_interface.sv
// Directed bench for axi_lite_interface: reset, read, backpressure, write, AR/AW arbitration, mid-transaction reset.

module tb_axi_lite_interface;

  logic                  clk;
  logic                  rst_n;
  ariane_axi::req_slv_t  req;
  ariane_axi::resp_slv_t resp;
  logic [63:0]           address;
  logic                  en;
  logic                  we;
  logic [63:0]           rdata;
  logic [63:0]           wdata;

  int n_checks = 0;
  int n_errors = 0;

  axi_lite_interface #(
    .AXI_ADDR_WIDTH(64),
    .AXI_DATA_WIDTH(64),
    .AXI_ID_WIDTH  (10)
  ) dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .axi_req_i (req),
    .axi_resp_o(resp),
    .address_o (address),
    .en_o      (en),
    .we_o      (we),
    .data_i    (rdata),
    .data_o    (wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    req   = '0;
    rdata = '0;
    rst_n = 1'b0;

    // Reset held with a pending AR
    req.ar_valid = 1'b1;
    req.ar.addr  = 64'hBFF8;
    req.ar.id    = 10'h3A;
    @(negedge clk);
    check("rst_ar_ready", 64'(resp.ar_ready), 64'd0);
    check("rst_r_valid",  64'(resp.r_valid),  64'd0);
    check("rst_en",       64'(en),            64'd0);
    check("rst_we",       64'(we),            64'd0);
    check("rst_addr",     address,            64'd0);
    check("rst_aw_ready", 64'(resp.aw_ready), 64'd0);

    step();
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_ar_ready", 64'(resp.ar_ready), 64'd1);
    check("idle_aw_ready", 64'(resp.aw_ready), 64'd0);

    // Read response with backpressure
    step();
    req.ar_valid = 1'b0;
    req.r_ready  = 1'b0;
    rdata        = 64'h1234_5678_9ABC_DEF0;
    @(negedge clk);
    check("rd_r_valid", 64'(resp.r_valid), 64'd1);
    check("rd_r_data",  resp.r.data,       64'h1234_5678_9ABC_DEF0);
    check("rd_r_id",    64'(resp.r.id),    64'h3A);
    check("rd_r_last",  64'(resp.r.last),  64'd1);
    check("rd_r_resp",  64'(resp.r.resp),  64'd0);
    check("rd_en",      64'(en),           64'd1);
    check("rd_we",      64'(we),           64'd0);
    check("rd_addr",    address,           64'hBFF8);
    check("rd_ar_ready",64'(resp.ar_ready),64'd0);

    for (int i = 0; i < 3; i++) begin
      step();
      rdata = 64'hA5A5_0000_0000_0000 + 64'(i);
      @(negedge clk);
      check("bp_r_valid", 64'(resp.r_valid), 64'd1);
      check("bp_en",      64'(en),           64'd1);
      check("bp_r_data",  resp.r.data,       64'hA5A5_0000_0000_0000 + 64'(i));
    end
    req.r_ready = 1'b1;
    #1;
    check("bp_hs_r_valid", 64'(resp.r_valid), 64'd1);
    step();
    req.r_ready = 1'b0;
    @(negedge clk);
    check("rd_done_r_valid", 64'(resp.r_valid), 64'd0);
    check("rd_done_en",      64'(en),           64'd0);

    // Write
    step();
    req.aw_valid = 1'b1;
    req.aw.addr  = 64'h4008;
    req.aw.id    = 10'h11;
    @(negedge clk);
    check("wr_aw_ready", 64'(resp.aw_ready), 64'd1);
    check("wr_ar_ready", 64'(resp.ar_ready), 64'd0);
    step();
    req.aw_valid = 1'b0;
    @(negedge clk);
    check("wr_w_ready_idle", 64'(resp.w_ready), 64'd1);
    check("wr_en_no_w",      64'(en),           64'd0);
    step();
    req.w_valid = 1'b1;
    req.w.data  = 64'hDEAD_BEEF_0000_0001;
    req.w.last  = 1'b1;
    req.b_ready = 1'b0;
    @(negedge clk);
    check("wr_w_ready", 64'(resp.w_ready), 64'd1);
    check("wr_en",      64'(en),           64'd1);
    check("wr_we",      64'(we),           64'd1);
    check("wr_addr",    address,           64'h4008);
    check("wr_data",    wdata,             64'hDEAD_BEEF_0000_0001);
    check("wr_b_valid_early", 64'(resp.b_valid), 64'd0);
    step();
    req.w_valid = 1'b0;
    @(negedge clk);
    check("wb_b_valid", 64'(resp.b_valid), 64'd1);
    check("wb_b_id",    64'(resp.b.id),    64'h11);
    check("wb_b_resp",  64'(resp.b.resp),  64'd0);
    check("wb_en",      64'(en),           64'd0);
    check("wb_we",      64'(we),           64'd0);
    req.b_ready = 1'b1;
    step();
    req.b_ready = 1'b0;
    @(negedge clk);
    check("wb_done_b_valid", 64'(resp.b_valid), 64'd0);

    // Simultaneous AR and AW: read first, AW held pending
    step();
    req.ar_valid = 1'b1;
    req.ar.addr  = 64'h10;
    req.ar.id    = 10'h1;
    req.aw_valid = 1'b1;
    req.aw.addr  = 64'h20;
    req.aw.id    = 10'h2;
    @(negedge clk);
    check("arb_ar_ready", 64'(resp.ar_ready), 64'd1);
    check("arb_aw_ready", 64'(resp.aw_ready), 64'd0);
    step();
    req.ar_valid = 1'b0;
    req.r_ready  = 1'b1;
    @(negedge clk);
    check("arb_r_valid",     64'(resp.r_valid),  64'd1);
    check("arb_r_id",        64'(resp.r.id),     64'h1);
    check("arb_aw_ready_rd", 64'(resp.aw_ready), 64'd0);
    step();
    req.r_ready = 1'b0;
    @(negedge clk);
    check("arb_aw_accept", 64'(resp.aw_ready), 64'd1);
    step();
    req.aw_valid = 1'b0;
    req.w_valid  = 1'b1;
    req.w.data   = 64'h0000_0000_CAFE_F00D;
    @(negedge clk);
    check("arb_we",   64'(we),  64'd1);
    check("arb_addr", address,  64'h20);
    step();
    req.w_valid = 1'b0;
    @(negedge clk);
    check("arb_b_valid", 64'(resp.b_valid), 64'd1);
    check("arb_b_id",    64'(resp.b.id),    64'h2);

    // Reset while WRITE_B is stalled
    #2;
    rst_n = 1'b0;
    #1;
    check("mrst_b_valid", 64'(resp.b_valid), 64'd0);
    check("mrst_en",      64'(en),           64'd0);
    check("mrst_addr",    address,           64'd0);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("post_rst_b_valid", 64'(resp.b_valid), 64'd0);
      check("post_rst_w_ready", 64'(resp.w_ready), 64'd0);
      step();
    end
    req.ar_valid = 1'b1;
    req.ar.addr  = 64'h8;
    req.ar.id    = 10'h5;
    @(negedge clk);
    check("post_rst_ar_ready", 64'(resp.ar_ready), 64'd1);
    step();
    req.ar_valid = 1'b0;
    @(negedge clk);
    check("post_rst_r_id", 64'(resp.r.id), 64'h5);
    check("post_rst_addr", address,        64'h8);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
